// File: rtl/flappy_game_core.sv
// Frame-rate game engine for a one-pipe flappy-bird clone: bird physics, scrolling pipe,
// collision, current and high score. Each clock edge is one game frame.
module flappy_game_core #(
  parameter int         BIRD_X     = 160,
  parameter int         BIRD_W     = 20,
  parameter int         BIRD_H     = 20,
  parameter int         START_Y    = 240,
  parameter int         GROUND_Y   = 440,
  parameter int         GRAVITY    = 1,
  parameter int         FLAP_VEL   = -8,
  parameter int         MAX_FALL   = 8,
  parameter int         PIPE_W     = 40,
  parameter int         GAP_H      = 120,
  parameter int         PIPE_SPEED = 2,
  parameter int         PIPE_START = 640,
  parameter int         GAP_BASE   = 64,
  parameter logic [7:0] LFSR_SEED  = 8'hA5
) (
  input  logic       i_clock,
  input  logic       i_reset,
  input  logic       i_flap,
  input  logic       i_pause,
  output logic       o_game_state,
  output logic [9:0] o_current_score,
  output logic [9:0] o_highest_score,
  output logic [9:0] o_bird_x,
  output logic [8:0] o_bird_y,
  output logic [9:0] o_pipe_x,
  output logic [8:0] o_gap_y
);

  typedef enum logic [1:0] {S_IDLE = 2'd0, S_RUN = 2'd1, S_OVER = 2'd2} state_t;

  localparam logic signed [11:0] L_BIRD_X   = 12'(BIRD_X);
  localparam logic signed [11:0] L_BIRD_W   = 12'(BIRD_W);
  localparam logic signed [11:0] L_BIRD_H   = 12'(BIRD_H);
  localparam logic signed [11:0] L_GROUND_Y = 12'(GROUND_Y);
  localparam logic signed [11:0] L_PIPE_W   = 12'(PIPE_W);
  localparam logic signed [11:0] L_GAP_H    = 12'(GAP_H);
  localparam logic signed [7:0]  L_FLAP_VEL = 8'(FLAP_VEL);
  localparam logic signed [7:0]  L_GRAVITY  = 8'(GRAVITY);
  localparam logic signed [7:0]  L_MAX_FALL = 8'(MAX_FALL);
  localparam logic [8:0]         L_START_Y  = 9'(START_Y);
  localparam logic [9:0]         L_PIPE_X0  = 10'(PIPE_START);
  localparam logic [9:0]         L_PIPE_SPD = 10'(PIPE_SPEED);
  localparam logic [8:0]         L_GAP_BASE = 9'(GAP_BASE);
  localparam logic [9:0]         L_SCORE_MAX = 10'd999;

  function automatic logic signed [7:0] fall_limit(input logic signed [7:0] v);
    logic signed [7:0] t;
    t = v + L_GRAVITY;
    return (t > L_MAX_FALL) ? L_MAX_FALL : t;
  endfunction

  function automatic logic [9:0] score_inc(input logic [9:0] s);
    return (s >= L_SCORE_MAX) ? L_SCORE_MAX : s + 10'd1;
  endfunction

  // Fibonacci LFSR for x^8+x^6+x^5+x^4+1
  function automatic logic [7:0] lfsr_step(input logic [7:0] q);
    return {q[6:0], q[7] ^ q[5] ^ q[4] ^ q[3]};
  endfunction

  state_t            r_state;
  logic              r_game_state;
  logic              r_flap_q;
  logic [8:0]        r_bird_y;
  logic signed [7:0] r_vel;
  logic [9:0]        r_pipe_x;
  logic [8:0]        r_gap_y;
  logic [7:0]        r_lfsr;
  logic [9:0]        r_cur_score;
  logic [9:0]        r_high_score;

  state_t            w_state_nxt;
  logic [8:0]        w_bird_y_nxt;
  logic signed [7:0] w_vel_nxt;
  logic [9:0]        w_pipe_x_nxt;
  logic [8:0]        w_gap_y_nxt;
  logic [7:0]        w_lfsr_nxt;
  logic [9:0]        w_cur_nxt;
  logic [9:0]        w_high_nxt;

  logic              w_flap_edge;
  logic signed [11:0] w_y_n;
  logic              w_y_neg;
  logic [8:0]        w_y_run;
  logic signed [7:0] w_vel_run;
  logic              w_reload;
  logic [7:0]        w_lfsr_run;
  logic [9:0]        w_pipe_run;
  logic [8:0]        w_gap_run;
  logic signed [11:0] w_ys, w_ps, w_gs, w_ps_old;
  logic              w_hit_ground, w_overlap, w_out_gap, w_collide, w_passed;
  logic [9:0]        w_score_run;

  assign w_flap_edge = i_flap & ~r_flap_q;

  // Position always advances with the velocity held at the start of the frame
  assign w_y_n     = $signed({3'b000, r_bird_y}) + $signed({{4{r_vel[7]}}, r_vel});
  assign w_y_neg   = w_y_n[11];
  assign w_y_run   = w_y_neg ? 9'd0 : w_y_n[8:0];
  assign w_vel_run = w_y_neg ? 8'sd0 : (w_flap_edge ? L_FLAP_VEL : fall_limit(r_vel));

  assign w_reload   = (r_pipe_x == 10'd0);
  assign w_lfsr_run = w_reload ? lfsr_step(r_lfsr) : r_lfsr;
  assign w_pipe_run = w_reload ? L_PIPE_X0 : r_pipe_x - L_PIPE_SPD;
  assign w_gap_run  = w_reload ? L_GAP_BASE + {1'b0, w_lfsr_run} : r_gap_y;

  assign w_ys     = $signed({3'b000, w_y_run});
  assign w_ps     = $signed({2'b00, w_pipe_run});
  assign w_gs     = $signed({3'b000, w_gap_run});
  assign w_ps_old = $signed({2'b00, r_pipe_x});

  assign w_hit_ground = (w_y_n + L_BIRD_H) >= L_GROUND_Y;
  assign w_overlap    = (L_BIRD_X + L_BIRD_W > w_ps) && (L_BIRD_X < w_ps + L_PIPE_W);
  assign w_out_gap    = (w_ys < w_gs) || (w_ys + L_BIRD_H > w_gs + L_GAP_H);
  assign w_collide    = w_hit_ground || (w_overlap && w_out_gap);
  // Pipe right edge crosses the bird's left edge during this frame
  assign w_passed     = (w_ps_old + L_PIPE_W >= L_BIRD_X) && (w_ps + L_PIPE_W < L_BIRD_X);
  assign w_score_run  = score_inc(r_cur_score);

  always_comb begin
    w_state_nxt  = r_state;
    w_bird_y_nxt = r_bird_y;
    w_vel_nxt    = r_vel;
    w_pipe_x_nxt = r_pipe_x;
    w_gap_y_nxt  = r_gap_y;
    w_lfsr_nxt   = r_lfsr;
    w_cur_nxt    = r_cur_score;
    w_high_nxt   = r_high_score;
    case (r_state)
      S_IDLE: begin
        if (w_flap_edge) begin
          w_state_nxt = S_RUN;
          w_vel_nxt   = L_FLAP_VEL;
          w_cur_nxt   = 10'd0;
        end
      end
      S_RUN: begin
        if (!i_pause) begin
          w_bird_y_nxt = w_y_run;
          w_vel_nxt    = w_vel_run;
          w_pipe_x_nxt = w_pipe_run;
          w_gap_y_nxt  = w_gap_run;
          w_lfsr_nxt   = w_lfsr_run;
          if (w_collide) begin
            w_state_nxt = S_OVER;
          end else if (w_passed) begin
            w_cur_nxt = w_score_run;
            if (w_score_run > r_high_score) w_high_nxt = w_score_run;
          end
        end
      end
      S_OVER: begin
        // LFSR and gap are intentionally kept so the next game sees a new pipe sequence
        if (w_flap_edge) begin
          w_state_nxt  = S_IDLE;
          w_bird_y_nxt = L_START_Y;
          w_vel_nxt    = 8'sd0;
          w_pipe_x_nxt = L_PIPE_X0;
        end
      end
      default: w_state_nxt = S_IDLE;
    endcase
  end

  always_ff @(posedge i_clock) begin
    if (i_reset) begin
      r_state      <= S_IDLE;
      r_game_state <= 1'b0;
      r_flap_q     <= 1'b0;
      r_bird_y     <= L_START_Y;
      r_vel        <= 8'sd0;
      r_pipe_x     <= L_PIPE_X0;
      r_lfsr       <= LFSR_SEED;
      r_gap_y      <= L_GAP_BASE + {1'b0, LFSR_SEED};
      r_cur_score  <= 10'd0;
      r_high_score <= 10'd0;
    end else begin
      r_state      <= w_state_nxt;
      r_game_state <= (w_state_nxt == S_RUN);
      r_flap_q     <= i_flap;
      r_bird_y     <= w_bird_y_nxt;
      r_vel        <= w_vel_nxt;
      r_pipe_x     <= w_pipe_x_nxt;
      r_lfsr       <= w_lfsr_nxt;
      r_gap_y      <= w_gap_y_nxt;
      r_cur_score  <= w_cur_nxt;
      r_high_score <= w_high_nxt;
    end
  end

  assign o_game_state    = r_game_state;
  assign o_current_score = r_cur_score;
  assign o_highest_score = r_high_score;
  assign o_bird_x        = 10'(BIRD_X);
  assign o_bird_y        = r_bird_y;
  assign o_pipe_x        = r_pipe_x;
  assign o_gap_y         = r_gap_y;

endmodule

// File: tb/tb_flappy_game_core.sv
// Directed bench for flappy_game_core: a frame-level reference model feeds a scoreboard
// that is compared against the DUT outputs one frame after each stimulus step.
module tb_flappy_game_core;

  logic       clk = 1'b0;
  logic       reset, flap, pause;
  logic       gs;
  logic [9:0] cur_score, high_score, bird_x, pipe_x;
  logic [8:0] bird_y, gap_y;

  int n_assert = 0;
  int n_fail   = 0;

  always #5 clk = ~clk;

  flappy_game_core dut (
    .i_clock        (clk),
    .i_reset        (reset),
    .i_flap         (flap),
    .i_pause        (pause),
    .o_game_state   (gs),
    .o_current_score(cur_score),
    .o_highest_score(high_score),
    .o_bird_x       (bird_x),
    .o_bird_y       (bird_y),
    .o_pipe_x       (pipe_x),
    .o_gap_y        (gap_y)
  );

  typedef struct packed {
    logic       gs;
    logic [9:0] cs;
    logic [9:0] hs;
    logic [8:0] y;
    logic [9:0] px;
    logic [8:0] gy;
  } exp_t;

  exp_t sb[$];

  // Reference model state (0 idle, 1 run, 2 over)
  int m_state = 0, m_y = 240, m_vel = 0, m_pipe = 640, m_gap = 229, m_lfsr = 165;
  int m_score = 0, m_high = 0;
  bit m_flap_q = 1'b0;

  function automatic int lfsr_next(input int q);
    int fb;
    fb = ((q >> 7) ^ (q >> 5) ^ (q >> 4) ^ (q >> 3)) & 1;
    return ((q << 1) & 255) | fb;
  endfunction

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] expv);
    n_assert++;
    assert (obs === expv) else begin
      n_fail++;
      $error("FAIL %s: observed %0d expected %0d", tag, obs, expv);
    end
  endtask

  task automatic model_step(input bit f, input bit p, input bit r);
    bit fe, col;
    int yn, ny, nv, np, ng, old;
    fe = f && !m_flap_q;
    if (r) begin
      m_state = 0; m_y = 240; m_vel = 0; m_pipe = 640; m_lfsr = 165; m_gap = 64 + 165;
      m_score = 0; m_high = 0;
    end else begin
      case (m_state)
        0: if (fe) begin m_state = 1; m_vel = -8; m_score = 0; end
        1: if (!p) begin
          yn = m_y + m_vel;
          if (yn < 0) begin ny = 0; nv = 0; end
          else begin ny = yn; nv = fe ? -8 : ((m_vel + 1 > 8) ? 8 : m_vel + 1); end
          if (m_pipe == 0) begin
            m_lfsr = lfsr_next(m_lfsr); np = 640; ng = 64 + m_lfsr;
          end else begin
            np = m_pipe - 2; ng = m_gap;
          end
          col = (yn + 20 >= 440) ||
                ((180 > np) && (160 < np + 40) && ((ny < ng) || (ny + 20 > ng + 120)));
          old = m_pipe;
          m_y = ny; m_vel = nv; m_pipe = np; m_gap = ng;
          if (col) m_state = 2;
          else if ((old + 40 >= 160) && (np + 40 < 160)) begin
            m_score = (m_score >= 999) ? 999 : m_score + 1;
            if (m_score > m_high) m_high = m_score;
          end
        end
        2: if (fe) begin m_state = 0; m_y = 240; m_vel = 0; m_pipe = 640; end
        default: m_state = 0;
      endcase
    end
    m_flap_q = r ? 1'b0 : f;
  endtask

  task automatic step(input bit f, input bit p, input bit r);
    exp_t e;
    flap = f; pause = p; reset = r;
    model_step(f, p, r);
    e.gs = (m_state == 1); e.cs = 10'(m_score); e.hs = 10'(m_high);
    e.y = 9'(m_y); e.px = 10'(m_pipe); e.gy = 9'(m_gap);
    sb.push_back(e);
    @(posedge clk); #1;
    e = sb.pop_front();
    chk("game_state", {31'd0, gs}, {31'd0, e.gs});
    chk("current_score", {22'd0, cur_score}, {22'd0, e.cs});
    chk("highest_score", {22'd0, high_score}, {22'd0, e.hs});
    chk("bird_y", {23'd0, bird_y}, {23'd0, e.y});
    chk("pipe_x", {22'd0, pipe_x}, {22'd0, e.px});
    chk("gap_y", {23'd0, gap_y}, {23'd0, e.gy});
    chk("bird_x", {22'd0, bird_x}, 32'd160);
  endtask

  // Flap whenever the bird sinks to 280, keeping it inside the first gap (229..349)
  task automatic play();
    bit f;
    f = (m_state == 1) && (m_y >= 280) && !m_flap_q;
    step(f, 1'b0, 1'b0);
  endtask

  int sy, sp;

  initial begin
    reset = 1'b1; flap = 1'b0; pause = 1'b0;
    step(0, 0, 1);
    step(0, 0, 1);
    for (int k = 0; k < 10; k++) step(0, 0, 0);
    chk("idle_gs", {31'd0, gs}, 32'd0);
    chk("idle_y", {23'd0, bird_y}, 32'd240);
    chk("idle_pipe", {22'd0, pipe_x}, 32'd640);
    chk("idle_gap", {23'd0, gap_y}, 32'd229);
    chk("idle_scores", {12'd0, cur_score, high_score}, 32'd0);

    // Start and fall to the ground
    step(1, 0, 0);
    chk("start_gs", {31'd0, gs}, 32'd1);
    chk("start_y", {23'd0, bird_y}, 32'd240);
    step(0, 0, 0);
    chk("rise_y1", {23'd0, bird_y}, 32'd232);
    step(0, 0, 0);
    chk("rise_y2", {23'd0, bird_y}, 32'd225);
    for (int k = 0; k < 100 && gs === 1'b1; k++) step(0, 0, 0);
    chk("fall_over_gs", {31'd0, gs}, 32'd0);
    chk("fall_over_y", {23'd0, bird_y}, 32'd424);

    // OVER -> IDLE -> RUN
    step(0, 0, 0); step(1, 0, 0);
    chk("restart_y", {23'd0, bird_y}, 32'd240);
    chk("restart_pipe", {22'd0, pipe_x}, 32'd640);
    step(0, 0, 0); step(1, 0, 0);
    chk("game2_gs", {31'd0, gs}, 32'd1);
    for (int k = 0; k < 30; k++) play();

    // Pause with flap toggling
    sy = m_y; sp = m_pipe;
    for (int k = 0; k < 20; k++) step(k[0], 1, 0);
    step(0, 1, 0);
    chk("pause_y", {23'd0, bird_y}, 32'(sy));
    chk("pause_pipe", {22'd0, pipe_x}, 32'(sp));
    chk("pause_gs", {31'd0, gs}, 32'd1);

    // Hold inside the gap until the pipe is passed
    for (int k = 0; k < 400 && cur_score === 10'd0; k++) play();
    chk("score1_cur", {22'd0, cur_score}, 32'd1);
    chk("score1_high", {22'd0, high_score}, 32'd1);
    chk("score1_pipe", {22'd0, pipe_x}, 32'd118);

    // Pipe wraps and draws a new gap from the LFSR
    for (int k = 0; k < 200 && pipe_x !== 10'd0; k++) play();
    chk("pipe_zero", {22'd0, pipe_x}, 32'd0);
    play();
    chk("reload_pipe", {22'd0, pipe_x}, 32'd640);
    chk("reload_gap", {23'd0, gap_y}, 32'd138);

    // Die with score 1
    for (int k = 0; k < 100 && gs === 1'b1; k++) step(0, 0, 0);
    chk("die1_gs", {31'd0, gs}, 32'd0);
    chk("die1_cur", {22'd0, cur_score}, 32'd1);
    step(0, 0, 0); step(1, 0, 0);
    chk("idle_keeps_score", {22'd0, cur_score}, 32'd1);
    step(0, 0, 0); step(1, 0, 0);
    chk("game3_cur", {22'd0, cur_score}, 32'd0);
    for (int k = 0; k < 100 && gs === 1'b1; k++) step(0, 0, 0);
    chk("die0_gs", {31'd0, gs}, 32'd0);
    chk("die0_high", {22'd0, high_score}, 32'd1);

    // Reset in the middle of a game
    step(0, 0, 0); step(1, 0, 0); step(0, 0, 0); step(1, 0, 0);
    for (int k = 0; k < 5; k++) play();
    chk("pre_reset_gs", {31'd0, gs}, 32'd1);
    step(0, 0, 1);
    chk("rst_gs", {31'd0, gs}, 32'd0);
    chk("rst_y", {23'd0, bird_y}, 32'd240);
    chk("rst_pipe", {22'd0, pipe_x}, 32'd640);
    chk("rst_gap", {23'd0, gap_y}, 32'd229);
    chk("rst_high", {22'd0, high_score}, 32'd0);
    step(0, 0, 0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
    $finish;
  end

endmodule
